lc4_dword_seq: RTL and testbench
================================

Name: lc4_dword_seq

Overview:
- Micro-sequencer that runs double-word (2×WORD_SIZE) operations on the single-word lc4 ALU.
- Accepts one command per transaction over a valid/ready handshake: negate, multi-bit shift right, or multi-bit shift left of a {hi,lo} operand pair.
- Issues one ALU instruction word per cycle and drives the ALU operand and carry inputs.
- Captures the combinational ALU result into hi/lo registers and returns the pair with a done pulse.
- Sits between the ECC point-arithmetic control and the ALU.

Parameters:
- WORD_SIZE, 256, width of one ALU word.
- INSN, 19, MSB index of the ALU instruction word (word is INSN+1 bits).
- CNT_W, 8, width of the shift-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  sequencer can accept a command.
- i_cmd_op  in  2  00=DNEG, 01=DSHR, 10=DSHL, 11=reserved.
- i_cmd_cnt  in  CNT_W  shift amount in bits; ignored for DNEG.
- i_op_hi  in  WORD_SIZE  upper operand word.
- i_op_lo  in  WORD_SIZE  lower operand word.
- i_abort  in  1  cancel the operation in flight.
- o_alu_insn  out  INSN+1  instruction word to the ALU; opcode in [19:15].
- o_alu_r1data  out  WORD_SIZE  ALU rs operand.
- o_alu_r2data  out  WORD_SIZE  ALU rt operand.
- o_alu_carry  out  1  ALU carry input.
- i_alu_result  in  WORD_SIZE  combinational ALU result.
- o_res_hi  out  WORD_SIZE  result upper word.
- o_res_lo  out  WORD_SIZE  result lower word.
- o_done  out  1  one-cycle pulse when the result is valid.
- o_err  out  1  one-cycle pulse when a reserved op is accepted.
- o_perf_cycles  out  32  ALU-issue cycle count (optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - Registers hi, lo, cnt, op, carry flag all 0.
  - o_done=0, o_err=0, o_res_hi/o_res_lo=0, o_perf_cycles=0.
  - Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, STEP_A, STEP_B, DONE.
- o_cmd_ready=1 only in IDLE.
- Accept: i_cmd_valid & o_cmd_ready at a clk edge.
  - Latch hi←i_op_hi, lo←i_op_lo, op, cnt.
  - Latch zflag←(i_op_lo==0).
- Next state after accept:
  - Reserved op: o_err pulses next cycle, state stays IDLE, result registers unchanged.
  - Shift with cnt==0: go to DONE, result equals operands.
  - Otherwise: go to STEP_A.
- Idle drive: in IDLE and DONE, o_alu_insn=0 (NOP), r1/r2=0, carry=0.
- DNEG:
  - STEP_A: insn opcode 10100 (TCS), r1=lo. Capture lo←result.
  - STEP_B: insn opcode 10101 (TCDH), r1=hi, carry=zflag. Capture hi←result.
  - Then DONE.
- DSHR, one bit per A/B pair:
  - STEP_A: opcode 01111 (SDRL), r1=hi, r2=lo. Capture lo.
  - STEP_B: opcode 01110 (SDRH), r1=hi. Capture hi.
- DSHL, one bit per A/B pair:
  - STEP_A: opcode 10010 (SDL), r1=hi, r2=lo. Capture hi.
  - STEP_B: opcode 01100 (SLL), insn[3:0]=1, r1=lo. Capture lo.
- Shift iteration: at the end of STEP_B, cnt←cnt−1. If cnt was 1, go to DONE; else go to STEP_A.
- Unused instruction bits are 0. r2 is 0 when not listed; carry is 0 except in the DNEG STEP_B.
- Latency, accept edge to o_done high:
  - DNEG: 3 cycles.
  - Shift: 2·cnt+1 cycles.
  - cnt==0: 1 cycle.
  - Max cnt=255 gives 511 cycles; shifts of WORD_SIZE or more bits zero/propagate correctly.
- DONE state: lasts one cycle.
  - o_done=1.
  - o_res_hi/o_res_lo←hi/lo; they hold until the next DONE or reset.
  - Next state IDLE.
- i_abort:
  - In STEP_A/STEP_B: return to IDLE next edge, no o_done, o_res_* unchanged.
  - In IDLE/DONE: ignored.
  - Reset has priority over abort.
- A command presented while busy is not accepted and must be held by the requester.

Optional Feature:
- Macro: LC4_DWORD_SEQ_PERF_EN.
- Defined:
  - o_perf_cycles increments by 1 on every STEP_A/STEP_B cycle, wraps at 2^32.
  - Cleared by reset only; unaffected by abort.
- Undefined: o_perf_cycles is tied to 0 and no counter logic exists.

Test Plan:
- DNEG with hi=0, lo=1 → o_done 3 cycles after accept; res hi=all-ones, lo=all-ones.
- DNEG with hi=1, lo=0 (zflag=1) → res hi=all-ones, lo=0. DNEG of hi=0, lo=0 → res 0,0.
- DSHR cnt=1, hi=1, lo=0 → res hi=0, lo=1<<(WORD_SIZE−1); DSHL cnt=1 of that result → hi=1, lo=0; done after 3 cycles each.
- DSHL cnt=4, hi=0, lo=F<<(WORD_SIZE−4) → hi=0xF, lo=0, done at cycle 9; DSHR cnt=0 → done at cycle 1, result equals operands.
- Abort asserted in the 2nd STEP_A of a DSHR cnt=5 → no done, o_cmd_ready=1 next cycle, o_res_* unchanged; rst_n=0 mid-DNEG → all outputs 0 next edge.
- Reserved op 11 → o_err pulse, no done. With LC4_DWORD_SEQ_PERF_EN, a DNEG followed by DSHR cnt=3 → o_perf_cycles=8.

Source files
------------

// File: rtl/lc4_dword_seq.sv
// rtl/lc4_dword_seq.sv - double-word negate/shift micro-sequencer driving the lc4 ALU (optional LC4_DWORD_SEQ_PERF_EN cycle counter)
module lc4_dword_seq #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [1:0]           i_cmd_op,
  input  logic [CNT_W-1:0]     i_cmd_cnt,
  input  logic [WORD_SIZE-1:0] i_op_hi,
  input  logic [WORD_SIZE-1:0] i_op_lo,
  input  logic                 i_abort,
  output logic [INSN:0]        o_alu_insn,
  output logic [WORD_SIZE-1:0] o_alu_r1data,
  output logic [WORD_SIZE-1:0] o_alu_r2data,
  output logic                 o_alu_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  output logic [WORD_SIZE-1:0] o_res_hi,
  output logic [WORD_SIZE-1:0] o_res_lo,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_perf_cycles
);

  localparam logic [1:0] OP_DNEG = 2'b00;
  localparam logic [1:0] OP_DSHR = 2'b01;
  localparam logic [1:0] OP_DSHL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [4:0] ALU_TCS  = 5'b10100;
  localparam logic [4:0] ALU_TCDH = 5'b10101;
  localparam logic [4:0] ALU_SDRL = 5'b01111;
  localparam logic [4:0] ALU_SDRH = 5'b01110;
  localparam logic [4:0] ALU_SDL  = 5'b10010;
  localparam logic [4:0] ALU_SLL  = 5'b01100;

  typedef enum logic [1:0] {IDLE, STEP_A, STEP_B, DONE} state_t;

  state_t                 state, state_nxt;
  logic [WORD_SIZE-1:0]   hi, lo;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             op;
  logic                   zflag;
  logic                   cap_hi;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state plus the ALU instruction/operands for the current step
  always_comb begin
    state_nxt    = state;
    o_alu_insn   = '0;
    o_alu_r1data = '0;
    o_alu_r2data = '0;
    o_alu_carry  = 1'b0;
    cap_hi       = 1'b0;
    o_cmd_ready  = (state == IDLE);
    case (state)
      IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_op == OP_RSVD)                         state_nxt = IDLE;
          else if (i_cmd_op != OP_DNEG && i_cmd_cnt == '0) state_nxt = DONE;
          else                                             state_nxt = STEP_A;
        end
      end
      STEP_A: begin
        case (op)
          OP_DNEG: begin
            o_alu_insn[INSN -: 5] = ALU_TCS;
            o_alu_r1data          = lo;
          end
          OP_DSHR: begin
            o_alu_insn[INSN -: 5] = ALU_SDRL;
            o_alu_r1data          = hi;
            o_alu_r2data          = lo;
          end
          default: begin
            o_alu_insn[INSN -: 5] = ALU_SDL;
            o_alu_r1data          = hi;
            o_alu_r2data          = lo;
            cap_hi                = 1'b1;
          end
        endcase
        state_nxt = i_abort ? IDLE : STEP_B;
      end
      STEP_B: begin
        case (op)
          OP_DNEG: begin
            o_alu_insn[INSN -: 5] = ALU_TCDH;
            o_alu_r1data          = hi;
            o_alu_carry           = zflag;
            cap_hi                = 1'b1;
          end
          OP_DSHR: begin
            o_alu_insn[INSN -: 5] = ALU_SDRH;
            o_alu_r1data          = hi;
            cap_hi                = 1'b1;
          end
          default: begin
            o_alu_insn[INSN -: 5] = ALU_SLL;
            o_alu_insn[3:0]       = 4'd1;
            o_alu_r1data          = lo;
          end
        endcase
        if (i_abort)                                    state_nxt = IDLE;
        else if (op == OP_DNEG || cnt == CNT_W'(1))     state_nxt = DONE;
        else                                            state_nxt = STEP_A;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, per-step result capture, result publish and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op       <= '0;
      zflag    <= 1'b0;
      o_res_hi <= '0;
      o_res_lo <= '0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            op <= i_cmd_op;
            if (i_cmd_op == OP_RSVD) begin
              o_err <= 1'b1;
            end else begin
              hi    <= i_op_hi;
              lo    <= i_op_lo;
              cnt   <= i_cmd_cnt;
              zflag <= (i_op_lo == '0);
            end
          end
        end
        STEP_A, STEP_B: begin
          if (!i_abort) begin
            if (cap_hi) hi <= i_alu_result;
            else        lo <= i_alu_result;
            if (state == STEP_B) cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          o_done   <= 1'b1;
          o_res_hi <= hi;
          o_res_lo <= lo;
        end
        default: ;
      endcase
    end
  end

`ifdef LC4_DWORD_SEQ_PERF_EN
  logic [31:0] perf;

  // count every ALU-issue cycle; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n)                                 perf <= '0;
    else if (state == STEP_A || state == STEP_B) perf <= perf + 32'd1;
  end

  assign o_perf_cycles = perf;
`else
  assign o_perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_lc4_dword_seq.sv
// tb/tb_lc4_dword_seq.sv - directed bench for lc4_dword_seq with a behavioural ALU
module tb_lc4_dword_seq;
  localparam int W = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [7:0]    cmd_cnt = '0;
  logic [W-1:0]  op_hi = '0, op_lo = '0;
  logic          abort = 1'b0;
  logic [19:0]   alu_insn;
  logic [W-1:0]  alu_r1, alu_r2, alu_result;
  logic          alu_carry;
  logic [W-1:0]  res_hi, res_lo;
  logic          done, err;
  logic [31:0]   perf_cycles;

  int errors = 0;
  int checks = 0;

  lc4_dword_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_cnt(cmd_cnt),
    .i_op_hi(op_hi), .i_op_lo(op_lo), .i_abort(abort),
    .o_alu_insn(alu_insn), .o_alu_r1data(alu_r1), .o_alu_r2data(alu_r2),
    .o_alu_carry(alu_carry), .i_alu_result(alu_result),
    .o_res_hi(res_hi), .o_res_lo(res_lo),
    .o_done(done), .o_err(err), .o_perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // behavioural model of the ALU operations the sequencer uses
  always_comb begin
    alu_result = '0;
    case (alu_insn[19:15])
      5'b10100: alu_result = ~alu_r1 + W'(1);
      5'b10101: alu_result = ~alu_r1 + W'(alu_carry);
      5'b01111: alu_result = {alu_r1[0], alu_r2[W-1:1]};
      5'b01110: alu_result = alu_r1 >> 1;
      5'b10010: alu_result = {alu_r1[W-2:0], alu_r2[W-1]};
      5'b01100: alu_result = alu_r1 << alu_insn[3:0];
      default:  alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one command and count cycles from the accept edge until o_done
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] cnt,
                         input logic [W-1:0] hi, input logic [W-1:0] lo,
                         output int lat);
    @(negedge clk);
    cmd_op = op; cmd_cnt = cnt; op_hi = hi; op_lo = lo; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (lat < 600) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
    end
    if (lat >= 600) check("timeout", W'(lat), W'(0));
  endtask

  logic [W-1:0] ones, msb, topf, hold_hi, hold_lo;
  int lat;

  initial begin
    ones = '1;
    msb  = W'(1) << (W-1);
    topf = W'(4'hF) << (W-4);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", W'(cmd_ready), W'(1));
    check("rst_done", W'(done), W'(0));
    check("rst_res_hi", res_hi, '0);
    check("rst_res_lo", res_lo, '0);
    check("rst_insn", W'(alu_insn), '0);
    check("rst_perf", W'(perf_cycles), '0);
    @(negedge clk) rst_n = 1'b1;

    // first step of a DNEG issues TCS on lo
    @(negedge clk);
    cmd_op = 2'b00; cmd_cnt = 8'd0; op_hi = '0; op_lo = W'(1); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("dneg_a_insn", W'(alu_insn), W'(20'hA0000));
    check("dneg_a_r1", alu_r1, W'(1));
    check("dneg_a_ready", W'(cmd_ready), W'(0));
    @(posedge clk);
    #1 check("dneg_b_insn", W'(alu_insn), W'(20'hA8000));
    @(posedge clk);
    #1 check("dneg_b_nodone", W'(done), W'(0));
    @(posedge clk);
    #1 check("dneg1_done", W'(done), W'(1));
    check("dneg1_hi", res_hi, ones);
    check("dneg1_lo", res_lo, ones);

    run_cmd(2'b00, 8'd0, W'(1), '0, lat);
    check("dneg2_lat", W'(lat), W'(3));
    check("dneg2_hi", res_hi, ones);
    check("dneg2_lo", res_lo, '0);

    run_cmd(2'b00, 8'd0, '0, '0, lat);
    check("dneg0_hi", res_hi, '0);
    check("dneg0_lo", res_lo, '0);

    run_cmd(2'b01, 8'd1, W'(1), '0, lat);
    check("dshr1_lat", W'(lat), W'(3));
    check("dshr1_hi", res_hi, '0);
    check("dshr1_lo", res_lo, msb);

    run_cmd(2'b10, 8'd1, '0, msb, lat);
    check("dshl1_lat", W'(lat), W'(3));
    check("dshl1_hi", res_hi, W'(1));
    check("dshl1_lo", res_lo, '0);

    run_cmd(2'b10, 8'd4, '0, topf, lat);
    check("dshl4_lat", W'(lat), W'(9));
    check("dshl4_hi", res_hi, W'(4'hF));
    check("dshl4_lo", res_lo, '0);

    run_cmd(2'b01, 8'd0, W'(16'h1234), W'(16'h5678), lat);
    check("dshr0_lat", W'(lat), W'(1));
    check("dshr0_hi", res_hi, W'(16'h1234));
    check("dshr0_lo", res_lo, W'(16'h5678));
    check("dshr0_pulse", W'(done), W'(1));
    @(posedge clk);
    #1 check("done_one_cycle", W'(done), W'(0));

    // abort during the second STEP_A of a 5-bit right shift
    hold_hi = res_hi; hold_lo = res_lo;
    @(negedge clk);
    cmd_op = 2'b01; cmd_cnt = 8'd5; op_hi = W'(1); op_lo = '0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("abort_in_sdrl", W'(alu_insn), W'(20'h78000));
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_ready", W'(cmd_ready), W'(1));
    check("abort_nodone", W'(done), W'(0));
    lat = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) lat++;
    end
    check("abort_no_late_done", W'(lat), W'(0));
    check("abort_res_hi", res_hi, hold_hi);
    check("abort_res_lo", res_lo, hold_lo);

    // reserved op pulses o_err without a result
    @(negedge clk);
    cmd_op = 2'b11; cmd_cnt = 8'd3; op_hi = ones; op_lo = ones; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("rsvd_err", W'(err), W'(1));
    check("rsvd_nodone", W'(done), W'(0));
    check("rsvd_ready", W'(cmd_ready), W'(1));
    @(posedge clk);
    #1 check("rsvd_err_pulse", W'(err), W'(0));
    check("rsvd_res_hi", res_hi, hold_hi);

    // reset mid-DNEG clears everything
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_cmd(2'b00, 8'd0, W'(1), '0, lat);
`ifdef LC4_DWORD_SEQ_PERF_EN
    run_cmd(2'b01, 8'd3, W'(8), '0, lat);
    check("perf_cycles", W'(perf_cycles), W'(8));
    check("perf_dshr3_hi", res_hi, W'(1));
`else
    check("perf_tied", W'(perf_cycles), '0);
`endif
    @(negedge clk);
    cmd_op = 2'b00; op_hi = ones; op_lo = W'(5); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_res_hi", res_hi, '0);
    check("rstmid_res_lo", res_lo, '0);
    check("rstmid_done", W'(done), W'(0));
    check("rstmid_insn", W'(alu_insn), '0);
    check("rstmid_ready", W'(cmd_ready), W'(1));
    check("rstmid_perf", W'(perf_cycles), '0);
    @(negedge clk) rst_n = 1'b1;
    lat = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (done) lat++;
    end
    check("rstmid_no_done", W'(lat), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
